// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst/response constants and captured AR request type
package axi_pkg;

  localparam logic [1:0] AXI_FIXED = 2'b00;
  localparam logic [1:0] AXI_INCR  = 2'b01;
  localparam logic [1:0] AXI_WRAP  = 2'b10;
  localparam logic [1:0] AXI_RSVD  = 2'b11;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ar_req_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_calc.sv
// rtl/axi_burst_addr_calc.sv - next beat address and request-level error for an AXI burst
module axi_burst_addr_calc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  req_err
);
  import axi_pkg::*;

  localparam int OFFS = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] mask;

  always_comb begin
    incr = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      AXI_INCR: next_addr = (addr & ~(incr - ADDR_WIDTH'(1))) + incr;
      AXI_WRAP: next_addr = (addr & ~mask) | ((addr + incr) & mask);
      default:  next_addr = addr;
    endcase
    req_err = (size > 3'(OFFS)) || (burst == AXI_RSVD) ||
              ((burst == AXI_WRAP) && !wrap_len_ok(len));
  end

endmodule

// File: rtl/axi_read_slave_mem.sv
// rtl/axi_read_slave_mem.sv - AXI4 read responder backed by a backdoor-loaded word memory
module axi_read_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 32,
  parameter int MEM_WORDS  = 256
) (
  input  logic                         sig_clock,
  input  logic                         sig_reset,
  input  logic [ID_WIDTH-1:0]          arid,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [ID_WIDTH-1:0]          rid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0]        bd_wdata
);
  import axi_pkg::*;

  localparam int OFFS = $clog2(DATA_WIDTH / 8);
  localparam int AW   = $clog2(MEM_WORDS);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  ar_req_t               req_q, req_d;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH-1:0] calc_addr, next_addr, load_addr;
  logic [7:0]            calc_len;
  logic [2:0]            calc_size;
  logic [1:0]            calc_burst;
  logic                  req_err, beat_err;
  logic [DATA_WIDTH-1:0] beat_rdata;
  logic [1:0]            beat_rresp;

  // In IDLE the calculator sees the incoming request so its error flag is valid at capture.
  always_comb begin
    if (state_q == S_IDLE) begin
      calc_addr  = araddr;
      calc_len   = arlen;
      calc_size  = arsize;
      calc_burst = arburst;
      load_addr  = araddr;
    end else begin
      calc_addr  = addr_q;
      calc_len   = req_q.len;
      calc_size  = req_q.size;
      calc_burst = req_q.burst;
      load_addr  = next_addr;
    end
    beat_err   = req_err || ((load_addr >> (OFFS + AW)) != '0);
    beat_rresp = beat_err ? AXI_SLVERR : AXI_OKAY;
    beat_rdata = beat_err ? '0 : mem[load_addr[OFFS +: AW]];
  end

  axi_burst_addr_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_addr_calc (
    .addr     (calc_addr),
    .size     (calc_size),
    .len      (calc_len),
    .burst    (calc_burst),
    .next_addr(next_addr),
    .req_err  (req_err)
  );

  always_comb begin
    state_d    = state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    req_d      = req_q;
    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        if (arvalid && arready_q) begin
          state_d    = S_BURST;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rid_d      = arid;
          req_d      = '{len: arlen, size: arsize, burst: arburst};
          addr_d     = araddr;
          beat_cnt_d = 8'd0;
          rlast_d    = (arlen == 8'd0);
          rdata_d    = beat_rdata;
          rresp_d    = beat_rresp;
        end
      end
      default: begin
        if (rready) begin
          if (rlast_q) begin
            state_d   = S_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            addr_d     = next_addr;
            beat_cnt_d = beat_cnt_q + 8'd1;
            rlast_d    = ((beat_cnt_q + 8'd1) == req_q.len);
            rdata_d    = beat_rdata;
            rresp_d    = beat_rresp;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      state_q    <= S_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      req_q      <= req_d;
    end
  end

  // Memory survives reset; the backdoor stays live so the bench can preload under reset.
  always_ff @(posedge sig_clock) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule
